// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed 7-segment scan controller with blank gaps and frame-aligned updates.
// Optional macro SEG7_HEX_DECODE_EN enables hex glyphs for codes 10..15.
`default_nettype none

module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 16630,
  parameter int BLANK_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    upd_valid,
  output logic                    upd_ready,
  input  logic [4*NUM_DIGITS-1:0] upd_digits,
  input  logic [NUM_DIGITS-1:0]   upd_dp,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic                    frame_tick
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]           cnt, cnt_next;
  logic [IW-1:0]           idx, idx_next;
  logic [4*NUM_DIGITS-1:0] active_digits, pend_digits, digits_sh;
  logic [NUM_DIGITS-1:0]   active_dp, pend_dp, dp_sh;
  logic                    pend_full;
  logic                    slot_end, frame_end, accept;
  logic [7:0]              seg_next;
  logic [NUM_DIGITS-1:0]   dig_en_next;

  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] abcdefg;
    case (code)
      4'd0:    abcdefg = 7'b1111110;
      4'd1:    abcdefg = 7'b0110000;
      4'd2:    abcdefg = 7'b1101101;
      4'd3:    abcdefg = 7'b1111001;
      4'd4:    abcdefg = 7'b0110011;
      4'd5:    abcdefg = 7'b1011011;
      4'd6:    abcdefg = 7'b1011111;
      4'd7:    abcdefg = 7'b1110000;
      4'd8:    abcdefg = 7'b1111111;
      4'd9:    abcdefg = 7'b1111011;
`ifdef SEG7_HEX_DECODE_EN
      4'd10:   abcdefg = 7'b1110111;
      4'd11:   abcdefg = 7'b0011111;
      4'd12:   abcdefg = 7'b1001110;
      4'd13:   abcdefg = 7'b0111101;
      4'd14:   abcdefg = 7'b1001111;
      4'd15:   abcdefg = 7'b1000111;
`endif
      default: abcdefg = 7'b0000000;
    endcase
    return abcdefg;
  endfunction

  assign upd_ready = ~pend_full;
  assign accept    = upd_valid & ~pend_full;
  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  always_comb begin
    cnt_next = slot_end ? '0 : cnt + 1'b1;
    idx_next = idx;
    if (slot_end) begin
      idx_next = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
  end

  // Outputs are built from next-cycle slot position so the registered pins track cnt exactly.
  always_comb begin
    state_next  = state;
    seg_next    = '0;
    dig_en_next = '0;
    digits_sh   = active_digits >> {idx_next, 2'b00};
    dp_sh       = active_dp >> idx_next;
    case (state)
      ST_BLANK: if (cnt_next == BLANK_END) state_next = ST_DRIVE;
      ST_DRIVE: if (slot_end) state_next = ST_BLANK;
      default:  state_next = ST_BLANK;
    endcase
    if (state_next == ST_DRIVE) begin
      dig_en_next = NUM_DIGITS'(1) << idx_next;
      seg_next    = {decode(digits_sh[3:0]), dp_sh[0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_BLANK;
      cnt           <= '0;
      idx           <= '0;
      seg           <= '0;
      dig_en        <= '0;
      frame_tick    <= 1'b0;
      active_digits <= '0;
      active_dp     <= '0;
      pend_digits   <= '0;
      pend_dp       <= '0;
      pend_full     <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      idx        <= idx_next;
      seg        <= seg_next;
      dig_en     <= dig_en_next;
      frame_tick <= frame_end;
      // accept is gated by ~pend_full, so these two branches never compete.
      if (frame_end && pend_full) begin
        active_digits <= pend_digits;
        active_dp     <= pend_dp;
        pend_full     <= 1'b0;
      end else if (accept) begin
        pend_digits <= upd_digits;
        pend_dp     <= upd_dp;
        pend_full   <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed self-checking bench for seg7_scan_ctrl (NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2).
`default_nettype none

module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        upd_valid;
  logic        upd_ready;
  logic [15:0] upd_digits;
  logic [3:0]  upd_dp;
  logic [7:0]  seg;
  logic [3:0]  dig_en;
  logic        frame_tick;

  int vectors = 0;
  int fails   = 0;
  int tc      = 0;
  int run_len = 0;
  int last_tick = 0;
  int ticks   = 0;
  logic [15:0] exp_digits;
  logic [3:0]  exp_dp;

  seg7_scan_ctrl #(
    .NUM_DIGITS  (4),
    .PRESCALE    (8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .upd_valid (upd_valid),
    .upd_ready (upd_ready),
    .upd_digits(upd_digits),
    .upd_dp    (upd_dp),
    .seg       (seg),
    .dig_en    (dig_en),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] glyph(input logic [3:0] c);
    case (c)
      4'd0: return 8'b11111100;
      4'd1: return 8'b01100000;
      4'd2: return 8'b11011010;
      4'd3: return 8'b11110010;
      4'd4: return 8'b01100110;
      4'd5: return 8'b10110110;
      4'd6: return 8'b10111110;
      4'd7: return 8'b11100000;
      4'd8: return 8'b11111110;
      4'd9: return 8'b11110110;
`ifdef SEG7_HEX_DECODE_EN
      4'd10: return 8'b11101110;
      4'd11: return 8'b00111110;
      4'd12: return 8'b10011100;
      4'd13: return 8'b01111010;
      4'd14: return 8'b10011110;
      4'd15: return 8'b10001110;
`endif
      default: return 8'b00000000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s at tc=%0d: observed %h expected %h", tag, tc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    tc++;
    @(negedge clk);
  endtask

  // Expected pins at cycle tc: slot position is tc mod 8, digit is (tc/8) mod 4.
  task automatic check_cycle();
    int cnt_e;
    int idx_e;
    logic [3:0]  dig_e;
    logic [7:0]  seg_e;
    logic [15:0] sh;
    cnt_e = tc % 8;
    idx_e = (tc / 8) % 4;
    dig_e = '0;
    seg_e = '0;
    if (cnt_e >= 2) begin
      dig_e = 4'b0001 << idx_e;
      sh    = exp_digits >> (4 * idx_e);
      seg_e = {glyph(sh[3:0]) & 8'hFE} | {7'b0, exp_dp[idx_e]};
    end
    chk("dig_en", {28'b0, dig_en}, {28'b0, dig_e});
    chk("seg", {24'b0, seg}, {24'b0, seg_e});
    chk("frame_tick", {31'b0, frame_tick}, {31'b0, (tc % 32 == 0) && (tc > 0)});
    chk("onehot", {31'b0, $countones(dig_en) <= 1}, 32'd1);
    if (dig_en != 4'b0000) begin
      run_len++;
    end else if (run_len != 0) begin
      chk("drive_len", run_len, 6);
      run_len = 0;
    end
    if (frame_tick) begin
      chk("tick_period", tc - last_tick, 32);
      last_tick = tc;
      ticks++;
    end
  endtask

  task automatic run_until(input int target);
    while (tc < target) begin
      tick();
      check_cycle();
    end
  endtask

  initial begin
    rst        = 1'b1;
    upd_valid  = 1'b0;
    upd_digits = 16'h0000;
    upd_dp     = 4'b0000;
    exp_digits = 16'h0000;
    exp_dp     = 4'b0000;
    repeat (3) @(negedge clk);
    chk("rst_seg", {24'b0, seg}, 32'd0);
    chk("rst_dig_en", {28'b0, dig_en}, 32'd0);
    chk("rst_frame_tick", {31'b0, frame_tick}, 32'd0);
    chk("rst_ready", {31'b0, upd_ready}, 32'd1);

    rst = 1'b0;
    tc  = 0;
    check_cycle();
    run_until(12);

    // First update lands mid frame 0 and shows from frame 1.
    upd_valid  = 1'b1;
    upd_digits = 16'h9321;
    upd_dp     = 4'b0100;
    tick();
    check_cycle();
    chk("ready_after_accept", {31'b0, upd_ready}, 32'd0);
    upd_valid  = 1'b0;
    upd_digits = 16'h0000;
    upd_dp     = 4'b0000;

    run_until(20);
    upd_valid  = 1'b1;
    upd_digits = 16'hFEDA;
    upd_dp     = 4'b0000;
    while (tc < 31) begin
      tick();
      check_cycle();
      chk("ready_stall", {31'b0, upd_ready}, 32'd0);
    end
    tick();
    exp_digits = 16'h9321;
    exp_dp     = 4'b0100;
    check_cycle();
    chk("ready_at_boundary", {31'b0, upd_ready}, 32'd1);
    tick();
    check_cycle();
    chk("ready_second_accept", {31'b0, upd_ready}, 32'd0);
    upd_valid  = 1'b0;

    run_until(64);
    exp_digits = 16'hFEDA;
    exp_dp     = 4'b0000;
    run_until(70);

    upd_valid  = 1'b1;
    upd_digits = 16'h5555;
    upd_dp     = 4'b1111;
    tick();
    check_cycle();
    chk("ready_third_accept", {31'b0, upd_ready}, 32'd0);
    upd_valid  = 1'b0;

    // Reset in the middle of digit 2's drive window with data still pending.
    run_until(82);
    rst = 1'b1;
    #1;
    chk("midrst_seg", {24'b0, seg}, 32'd0);
    chk("midrst_dig_en", {28'b0, dig_en}, 32'd0);
    chk("midrst_ready", {31'b0, upd_ready}, 32'd1);
    chk("midrst_tick", {31'b0, frame_tick}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst        = 1'b0;
    tc         = 0;
    run_len    = 0;
    last_tick  = 0;
    ticks      = 0;
    exp_digits = 16'h0000;
    exp_dp     = 4'b0000;
    check_cycle();
    chk("restart_ready", {31'b0, upd_ready}, 32'd1);
    run_until(320);
    chk("tick_count", ticks, 10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-multiplexing controller for a common 8-bit segment bus shared by NUM_DIGITS 7-segment digits.
- Cycles through the digits with a prescaled slot timer and inserts an anti-ghosting blank gap before each digit.
- Accepts new display contents through a valid/ready handshake and applies them only at frame boundaries, so a frame never mixes old and new digits.
- Sits between the counter/BCD logic and the board segment and digit-select pins.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits; legal range 1..8.
- PRESCALE, 16630, clk cycles per digit slot (1 kHz slot rate at 16.63 MHz); must be > BLANK_CYCLES.
- BLANK_CYCLES, 64, cycles at the start of each slot with all digits and segments off; must be >= 1.

Ports:
- clk  input  1  system clock (internal oscillator domain).
- rst  input  1  reset, asynchronous, active-high.
- upd_valid  input  1  update request; upd_digits and upd_dp are valid.
- upd_ready  output  1  update can be accepted; equals NOT pend_full.
- upd_digits  input  4*NUM_DIGITS  nibble k is the code for digit k; digit 0 is the LSB nibble.
- upd_dp  input  NUM_DIGITS  decimal point per digit.
- seg  output  8  {A,B,C,D,E,F,G,DP}, A at the MSB, active-high.
- dig_en  output  NUM_DIGITS  one-hot digit select, active-high.
- frame_tick  output  1  one-cycle pulse at each frame boundary.

Behaviour:
- Reset (async assert, all registered):
  - seg=0, dig_en=0, frame_tick=0.
  - slot counter cnt=0, digit index idx=0.
  - Active digit and DP registers = 0. pend_full=0, so upd_ready=1.
- Slot timing:
  - cnt counts 0..PRESCALE-1 and then wraps to 0.
  - On wrap, idx increments; idx wraps NUM_DIGITS-1 -> 0.
  - Frame length is NUM_DIGITS*PRESCALE cycles.
- Two-state FSM per slot:
  - BLANK while cnt < BLANK_CYCLES: seg=0, dig_en=0.
  - DRIVE otherwise: dig_en=one-hot(idx), seg=decode(active nibble idx) with DP bit = active dp[idx].
  - Outputs are registered and change only on clk edges.
  - After reset deasserts, the first BLANK_CYCLES cycles are blank, then digit 0 drives for PRESCALE-BLANK_CYCLES cycles.
  - No two dig_en bits are ever high together, and dig_en never changes directly from one nonzero value to another.
- Decode (abcdefg,dp):
  - 0=11111100, 1=01100000, 2=11011010, 3=11110010, 4=01100110
  - 5=10110110, 6=10111110, 7=11100000, 8=11111110, 9=11110110
  - 10..15 = 00000000 unless the Optional Feature is enabled.
  - DP bit forced from dp[idx].
- Handshake:
  - Transfer occurs when upd_valid & upd_ready on a clk edge; data is captured into the pending registers and pend_full is set.
  - While pend_full=1, upd_ready=0; the requester must hold its data.
- Frame boundary (idx=NUM_DIGITS-1 and cnt=PRESCALE-1):
  - On the next edge frame_tick=1 for exactly one cycle.
  - If pend_full, active<=pending and pend_full<=0 on that same edge.
  - New data is therefore first visible on digit 0 of the new frame.
- Simultaneous events:
  - A transfer on the boundary edge is impossible when pend_full=1.
  - When pend_full=0 and a transfer lands on the boundary edge, the data goes to pending and becomes active at the following boundary.
- Multiple updates within one frame: only one can be pending; later ones stall.
- No frame_tick is generated during or directly out of reset.
- Mid-operation reset clears pending data without applying it.

Optional Feature:
- Macro SEG7_HEX_DECODE_EN.
- When defined, codes 10..15 decode as hex glyphs:
  - A=11101110, b=00111110, C=10011100
  - d=01111010, E=10011110, F=10001110
- When undefined, codes 10..15 blank the digit (seg=0 except DP).
- DP behaviour is unchanged either way.

Test Plan (NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2 unless stated):
- Reset release, no update -> per slot: 2 cycles dig_en=0000, then 6 cycles dig_en=0001, seg=11111100, repeating over 0010, 0100, 1000. First frame_tick occurs at cycle 32 after reset release.
- upd_digits=16'h9321, upd_dp=4'b0100, pulsed mid-frame 0 -> upd_ready drops next cycle. At the frame_tick edge upd_ready returns to 1. Frame 1 shows seg 01100000, 11011010, 11110011, 11110110 on digits 0..3.
- Second upd_valid held while pend_full=1 -> upd_ready=0 until frame_tick; accepted on the cycle after frame_tick; visible one frame later.
- upd_digits=16'hFEDA -> without macro, seg=00000000 during all DRIVE cycles. With SEG7_HEX_DECODE_EN: 11101110, 01111010, 10011110, 10001110.
- rst asserted for 1 cycle mid-DRIVE of digit 2 with pend_full=1 -> same-cycle seg=0, dig_en=0, upd_ready=1. Restarts at digit 0 showing 0; pending data discarded.
- Check over 10 frames: popcount(dig_en) <= 1 every cycle; each DRIVE run is exactly 6 cycles; frame_tick period is exactly 32 cycles.
